// File: rtl/multicycle_datapath.sv
// Multicycle ARM datapath: unified memory port, one ALU reused across cycles, register file,
// non-architectural latches (IR, Data, A, WD, ALUOut) and a split-enable NZCV flags register.
module multicycle_datapath #(
    parameter int               WIDTH  = 32,
    parameter logic [WIDTH-1:0] PC_RST = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PCWrite,
    input  logic             AdrSrc,
    input  logic             IRWrite,
    input  logic [1:0]       RegSrc,
    input  logic             RegWrite,
    input  logic [1:0]       ImmSrc,
    input  logic             ALUSrcA,
    input  logic [1:0]       ALUSrcB,
    input  logic [1:0]       ALUControl,
    input  logic [1:0]       ResultSrc,
    input  logic [1:0]       FlagWrite,
    input  logic [WIDTH-1:0] ReadData,
    output logic [WIDTH-1:0] Adr,
    output logic [WIDTH-1:0] WriteData,
    output logic [31:0]      Instr,
    output logic [3:0]       ALUFlags,
    output logic [3:0]       Flags
);

    logic [WIDTH-1:0] pc, data_r, a_r, wd_r, aluout_r;
    logic [31:0]      ir;
    logic [3:0]       flags_r;
    logic [WIDTH-1:0] rf [0:14];

    logic [3:0]       ra1, ra2, rd_idx;
    logic [WIDTH-1:0] rd1, rd2, pc_plus4;
    logic [WIDTH-1:0] ext_imm, srca, srcb, alu_y, result;
    logic [3:0]       alu_nzcv;

    // Returns {N, Z, C, V, Y}; C and V are only meaningful for add/sub.
    function automatic logic [WIDTH+3:0] alu_eval(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [1:0]       ctl);
        logic [WIDTH:0]          s;
        logic signed [WIDTH-1:0] y;
        logic                    c, v;
        s = '0;
        y = '0;
        c = 1'b0;
        v = 1'b0;
        case (ctl)
            2'b00: begin
                s = {1'b0, a} + {1'b0, b};
                y = s[WIDTH-1:0];
                c = s[WIDTH];
                v = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
            end
            2'b01: begin
                s = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
                y = s[WIDTH-1:0];
                c = s[WIDTH];
                v = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
            end
            2'b10:   y = a & b;
            default: y = a | b;
        endcase
        return {y < 0, y == '0, c, v, y};
    endfunction

    // Operand selection and register read; R15 reads as the already-incremented PC plus 4.
    assign pc_plus4 = pc + WIDTH'(4);
    assign ra1      = RegSrc[0] ? 4'd15 : ir[19:16];
    assign ra2      = RegSrc[1] ? ir[15:12] : ir[3:0];
    assign rd_idx   = ir[15:12];
    assign rd1      = (ra1 == 4'd15) ? pc_plus4 : rf[ra1];
    assign rd2      = (ra2 == 4'd15) ? pc_plus4 : rf[ra2];

    always_comb begin
        ext_imm = '0;
        case (ImmSrc)
            2'b00:   ext_imm = {{(WIDTH-8){1'b0}}, ir[7:0]};
            2'b01:   ext_imm = {{(WIDTH-12){1'b0}}, ir[11:0]};
            2'b10:   ext_imm = {{(WIDTH-26){ir[23]}}, ir[23:0], 2'b00};
            default: ext_imm = '0;
        endcase
    end

    always_comb begin
        srcb = '0;
        case (ALUSrcB)
            2'b00:   srcb = wd_r;
            2'b01:   srcb = ext_imm;
            2'b10:   srcb = WIDTH'(4);
            default: srcb = '0;
        endcase
    end

    assign srca                = ALUSrcA ? pc : a_r;
    assign {alu_nzcv, alu_y}   = alu_eval(srca, srcb, ALUControl);

    always_comb begin
        result = aluout_r;
        case (ResultSrc)
            2'b01:   result = data_r;
            2'b10:   result = alu_y;
            default: result = aluout_r;
        endcase
    end

    // State update: latches reload every cycle, architectural state only when enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= PC_RST;
            ir       <= '0;
            data_r   <= '0;
            a_r      <= '0;
            wd_r     <= '0;
            aluout_r <= '0;
            flags_r  <= '0;
            for (int i = 0; i < 15; i++) rf[i] <= '0;
        end else begin
            data_r   <= ReadData;
            a_r      <= rd1;
            wd_r     <= rd2;
            aluout_r <= alu_y;
            if (PCWrite) pc <= result;
            if (IRWrite) ir <= ReadData[31:0];
            if (RegWrite && rd_idx != 4'd15) rf[rd_idx] <= result;
            if (FlagWrite[1]) flags_r[3:2] <= alu_nzcv[3:2];
            if (FlagWrite[0]) flags_r[1:0] <= alu_nzcv[1:0];
        end
    end

    assign Adr       = AdrSrc ? result : pc;
    assign WriteData = wd_r;
    assign Instr     = ir;
    assign ALUFlags  = alu_nzcv;
    assign Flags     = flags_r;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Bench for multicycle_datapath: table of ALU vectors plus hand-written multicycle sequences,
// with expected values queued on a scoreboard when stimulus is driven.
module tb_multicycle_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCWrite, AdrSrc, IRWrite, RegWrite, ALUSrcA;
    logic [1:0]  RegSrc, ImmSrc, ALUSrcB, ALUControl, ResultSrc, FlagWrite;
    logic [31:0] ReadData, Adr, WriteData, Instr;
    logic [3:0]  ALUFlags, Flags;

    multicycle_datapath #(.WIDTH(32), .PC_RST(32'h0)) dut (
        .clk(clk), .reset(reset), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .RegSrc(RegSrc), .RegWrite(RegWrite), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ResultSrc(ResultSrc),
        .FlagWrite(FlagWrite), .ReadData(ReadData), .Adr(Adr), .WriteData(WriteData),
        .Instr(Instr), .ALUFlags(ALUFlags), .Flags(Flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] y;
        logic [3:0]  nzcv;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[8];
    int   total = 0;
    int   bad   = 0;

    task automatic push_exp(input string nm, input logic [31:0] v);
        exp_t e;
        e.name = nm;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] act);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty: got %h with no expectation queued", act);
        end else begin
            e = sb.pop_front();
            if (act !== e.val) begin
                bad++;
                $display("FAIL %s: got %h want %h", e.name, act, e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        PCWrite = 0; AdrSrc = 0; IRWrite = 0; RegWrite = 0; ALUSrcA = 0;
        RegSrc = 2'b00; ImmSrc = 2'b00; ALUSrcB = 2'b00; ALUControl = 2'b00;
        ResultSrc = 2'b00; FlagWrite = 2'b00;
    endtask

    task automatic load_reg(input logic [3:0] idx, input logic [31:0] val);
        idle();
        ReadData = {12'h000, idx, idx, 4'h0, 4'h0, idx};
        IRWrite  = 1;
        step();
        idle();
        ReadData = val;
        step();
        idle();
        ResultSrc = 2'b01;
        RegWrite  = 1;
        step();
        idle();
    endtask

    task automatic set_pc(input logic [31:0] val);
        idle();
        ReadData = val;
        step();
        ResultSrc = 2'b01;
        PCWrite   = 1;
        step();
        idle();
    endtask

    // A observed through the ALU as A | 0 on the address port.
    task automatic show_a();
        idle();
        ALUSrcA = 0; ALUSrcB = 2'b11; ALUControl = 2'b11; ResultSrc = 2'b10; AdrSrc = 1;
        #1;
    endtask

    initial begin
        tbl[0] = '{32'h0000_0005, 32'h0000_0003, 2'b00, 32'h0000_0008, 4'b0000};
        tbl[1] = '{32'h0000_0005, 32'h0000_0005, 2'b01, 32'h0000_0000, 4'b0110};
        tbl[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 2'b00, 32'h8000_0000, 4'b1001};
        tbl[3] = '{32'h0000_0003, 32'h0000_0005, 2'b01, 32'hFFFF_FFFE, 4'b1000};
        tbl[4] = '{32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 32'h0000_0000, 4'b0110};
        tbl[5] = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, 2'b10, 32'h00F0_00F0, 4'b0000};
        tbl[6] = '{32'h8000_0000, 32'h0000_0001, 2'b11, 32'h8000_0001, 4'b1000};
        tbl[7] = '{32'h8000_0000, 32'h0000_0001, 2'b01, 32'h7FFF_FFFF, 4'b0011};

        reset    = 1;
        ReadData = 32'h0;
        idle();
        step();
        step();
        push_exp("reset_adr", 32'h0);       check(Adr);
        push_exp("reset_instr", 32'h0);     check(Instr);
        push_exp("reset_flags", 32'h0);     check({28'h0, Flags});
        push_exp("reset_wdata", 32'h0);     check(WriteData);
        reset = 0;
        step();

        // Fetch: IR <= mem, PC <= PC + 4
        ReadData = 32'hE281_1005;
        IRWrite = 1; ALUSrcA = 1; ALUSrcB = 2'b10; ALUControl = 2'b00;
        ResultSrc = 2'b10; PCWrite = 1;
        #1;
        push_exp("fetch_adr_pc0", 32'h0);   check(Adr);
        step();
        idle();
        #1;
        push_exp("fetch_instr", 32'hE281_1005); check(Instr);
        push_exp("fetch_pc4", 32'h4);           check(Adr);

        // R15 read through port 1 gives PC + 4
        RegSrc = 2'b01;
        step();
        show_a();
        push_exp("r15_read_a", 32'h8);      check(Adr);

        // ALU vector table: SrcA = PC, SrcB = WD (= R1)
        for (int i = 0; i < 8; i++) begin
            load_reg(4'd1, tbl[i].b);
            set_pc(tbl[i].a);
            ALUSrcA = 1; ALUSrcB = 2'b00; ALUControl = tbl[i].op; ResultSrc = 2'b10; AdrSrc = 1;
            push_exp($sformatf("alu_y[%0d]", i), tbl[i].y);
            push_exp($sformatf("alu_flags[%0d]", i), {28'h0, tbl[i].nzcv});
            push_exp($sformatf("flags_reg[%0d]", i), {28'h0, tbl[i].nzcv});
            #1;
            check(Adr);
            check({28'h0, ALUFlags});
            FlagWrite = 2'b11;
            step();
            check({28'h0, Flags});
            FlagWrite = 2'b00;
        end

        // Split flag enables: PC=0x80000000, WD=1, Flags=0011
        ALUControl = 2'b10; FlagWrite = 2'b10;
        step();
        push_exp("split_nz_only", 32'h7);   check({28'h0, Flags});
        ALUControl = 2'b11; FlagWrite = 2'b01;
        step();
        push_exp("split_cv_only", 32'h4);   check({28'h0, Flags});
        idle();

        // Same-cycle write and read of R2: A captures the old value
        load_reg(4'd2, 32'h0000_AAAA);
        ReadData = 32'h0000_5555;
        step();
        ResultSrc = 2'b01; RegWrite = 1;
        step();
        show_a();
        push_exp("rw_same_cycle_old", 32'h0000_AAAA); check(Adr);
        step();
        push_exp("rw_next_cycle_new", 32'h0000_5555); check(Adr);

        // Write to R15 is ignored; both read ports of index 15 return PC + 4
        set_pc(32'h40);
        load_reg(4'd15, 32'h0000_DEAD);
        RegSrc = 2'b01;
        step();
        push_exp("r15_write_ignored_wd", 32'h44); check(WriteData);
        show_a();
        push_exp("r15_write_ignored_a", 32'h44);  check(Adr);

        // Immediate extension and branch target
        idle();
        ReadData = 32'hEAFF_FFFE;
        IRWrite  = 1;
        step();
        set_pc(32'h100);
        ALUSrcA = 1; ALUSrcB = 2'b01; ALUControl = 2'b00; ResultSrc = 2'b10; AdrSrc = 1;
        ImmSrc = 2'b00; #1; push_exp("ext_imm8", 32'h1FE);   check(Adr);
        ImmSrc = 2'b01; #1; push_exp("ext_imm12", 32'h10FE); check(Adr);
        ImmSrc = 2'b11; #1; push_exp("ext_zero", 32'h100);   check(Adr);
        ImmSrc = 2'b10; #1; push_exp("branch_target", 32'hF8); check(Adr);
        PCWrite = 1;
        step();
        idle();
        #1;
        push_exp("branch_pc", 32'hF8);      check(Adr);

        // Asynchronous reset between edges clears state immediately
        @(negedge clk);
        #1;
        reset = 1;
        #1;
        push_exp("midrst_adr", 32'h0);      check(Adr);
        push_exp("midrst_instr", 32'h0);    check(Instr);
        push_exp("midrst_flags", 32'h0);    check({28'h0, Flags});
        push_exp("midrst_wdata", 32'h0);    check(WriteData);
        step();
        reset = 0;
        step();
        push_exp("post_reset_fetch_adr", 32'h0); check(Adr);

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
